// File: rtl/wmv_pkg.sv
// Shared types and constants for the weighted majority vote sequencer.
package wmv_pkg;

    localparam int unsigned WMV_N_VOTERS = 32'd4;
    localparam int unsigned WMV_W_WIDTH  = 32'd3;
    localparam int unsigned WMV_WINDOW   = 32'd8;

    // Weight every voter gets after reset.
    localparam int unsigned WMV_DEFAULT_WEIGHT = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_ACCUM  = 2'b10,
        ST_DECIDE = 2'b11
    } wmv_state_e;

    // Accumulator width big enough for WINDOW samples of every voter at full weight.
    function automatic int unsigned wmv_sum_w(input int unsigned window,
                                              input int unsigned n_voters,
                                              input int unsigned w_width);
        wmv_sum_w = $clog2(window * n_voters * ((32'd1 << w_width) - 32'd1) + 32'd1);
    endfunction

endpackage

// File: rtl/wmv_weighted_sum.sv
// Combinational weighted popcount: splits the weight table into yes and no
// partial sums according to the current voter bits.
module wmv_weighted_sum #(
    parameter int unsigned N_VOTERS = 32'd4,
    parameter int unsigned W_WIDTH  = 32'd3,
    parameter int unsigned SUM_W    = 32'd8
) (
    input  logic [N_VOTERS-1:0]         vote_i,
    input  logic [N_VOTERS*W_WIDTH-1:0] weights_i,
    output logic [SUM_W-1:0]            yes_sum_o,
    output logic [SUM_W-1:0]            no_sum_o
);

    // Route each voter's weight to the yes or no total.
    always_comb begin
        yes_sum_o = '0;
        no_sum_o  = '0;
        for (int i = 0; i < int'(N_VOTERS); i++) begin
            if (vote_i[i]) begin
                yes_sum_o = yes_sum_o + SUM_W'(weights_i[i*W_WIDTH +: W_WIDTH]);
            end else begin
                no_sum_o  = no_sum_o + SUM_W'(weights_i[i*W_WIDTH +: W_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/wmv_vote_sequencer.sv
// Weighted majority vote sequencer: serial weight load, windowed weighted
// accumulation of voter bits, and a registered decision with a valid pulse.
module wmv_vote_sequencer
    import wmv_pkg::*;
#(
    parameter  int unsigned N_VOTERS = WMV_N_VOTERS,
    parameter  int unsigned W_WIDTH  = WMV_W_WIDTH,
    parameter  int unsigned WINDOW   = WMV_WINDOW,
    localparam int unsigned SUM_W    = wmv_sum_w(WINDOW, N_VOTERS, W_WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                cfg_mode,
    input  logic                cfg_bit,
    input  logic                cfg_strobe,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_in,
    output logic                busy,
    output logic                cfg_done,
    output logic                dec_valid,
    output logic                decision,
    output logic                tie,
    output logic [SUM_W-1:0]    sum_yes
);

    localparam int unsigned TBITS  = N_VOTERS * W_WIDTH;
    localparam int unsigned BIT_W  = (TBITS > 32'd1) ? $clog2(TBITS) : 32'd1;
    localparam int unsigned SAMP_W = (WINDOW > 32'd1) ? $clog2(WINDOW) : 32'd1;
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(TBITS - 32'd1);
    localparam logic [SAMP_W-1:0]  LAST_SAMP = SAMP_W'(WINDOW - 32'd1);
    localparam logic [W_WIDTH-1:0] DEF_W     = W_WIDTH'(WMV_DEFAULT_WEIGHT);

    wmv_state_e         state_q, state_d;
    logic [TBITS-1:0]   weights_q, weights_d;
    logic [TBITS-1:0]   shadow_q, shadow_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SAMP_W-1:0]  samp_cnt_q, samp_cnt_d;
    logic [SUM_W-1:0]   yes_acc_q, yes_acc_d;
    logic [SUM_W-1:0]   no_acc_q, no_acc_d;
    logic               busy_q, busy_d;
    logic               cfg_done_q, cfg_done_d;
    logic               dec_valid_q, dec_valid_d;
    logic               decision_q, decision_d;
    logic               tie_q, tie_d;
    logic [SUM_W-1:0]   sum_yes_q, sum_yes_d;
    logic [SUM_W-1:0]   yes_part_s;
    logic [SUM_W-1:0]   no_part_s;

    wmv_weighted_sum #(
        .N_VOTERS (N_VOTERS),
        .W_WIDTH  (W_WIDTH),
        .SUM_W    (SUM_W)
    ) u_wsum (
        .vote_i    (vote_in),
        .weights_i (weights_q),
        .yes_sum_o (yes_part_s),
        .no_sum_o  (no_part_s)
    );

    // Next-state and output computation for the load/accumulate/decide sequence.
    always_comb begin
        state_d     = state_q;
        weights_d   = weights_q;
        shadow_d    = shadow_q;
        bit_cnt_d   = bit_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        yes_acc_d   = yes_acc_q;
        no_acc_d    = no_acc_q;
        cfg_done_d  = 1'b0;
        dec_valid_d = 1'b0;
        decision_d  = decision_q;
        tie_d       = tie_q;
        sum_yes_d   = sum_yes_q;

        case (state_q)
            ST_IDLE: begin
                // Configuration has priority; a simultaneous start is dropped.
                if (cfg_mode) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                end else if (start) begin
                    state_d    = ST_ACCUM;
                    yes_acc_d  = '0;
                    no_acc_d   = '0;
                    samp_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!ena) begin
                    state_d = ST_LOAD;
                end else if (!cfg_mode) begin
                    // Abort: the live table keeps its previous contents.
                    state_d = ST_IDLE;
                end else if (cfg_strobe) begin
                    shadow_d = {shadow_q[TBITS-2:0], cfg_bit};
                    if (bit_cnt_q == LAST_BIT) begin
                        weights_d  = shadow_d;
                        cfg_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ACCUM: begin
                if (ena) begin
                    yes_acc_d = yes_acc_q + yes_part_s;
                    no_acc_d  = no_acc_q + no_part_s;
                    if (samp_cnt_q == LAST_SAMP) begin
                        state_d = ST_DECIDE;
                    end else begin
                        samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DECIDE: begin
                decision_d  = (yes_acc_q > no_acc_q);
                tie_d       = (yes_acc_q == no_acc_q);
                sum_yes_d   = yes_acc_q;
                dec_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, weight table, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            weights_q   <= {N_VOTERS{DEF_W}};
            shadow_q    <= '0;
            bit_cnt_q   <= '0;
            samp_cnt_q  <= '0;
            yes_acc_q   <= '0;
            no_acc_q    <= '0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            dec_valid_q <= 1'b0;
            decision_q  <= 1'b0;
            tie_q       <= 1'b0;
            sum_yes_q   <= '0;
        end else begin
            state_q     <= state_d;
            weights_q   <= weights_d;
            shadow_q    <= shadow_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            yes_acc_q   <= yes_acc_d;
            no_acc_q    <= no_acc_d;
            busy_q      <= busy_d;
            cfg_done_q  <= cfg_done_d;
            dec_valid_q <= dec_valid_d;
            decision_q  <= decision_d;
            tie_q       <= tie_d;
            sum_yes_q   <= sum_yes_d;
        end
    end

    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;
    assign dec_valid = dec_valid_q;
    assign decision  = decision_q;
    assign tie       = tie_q;
    assign sum_yes   = sum_yes_q;

endmodule
